dds_wavegen_mc: RTL and testbench

Multi-channel direct digital synthesis waveform generator.
- Each of NCH channels runs its own phase accumulator, advanced on a shared programmable sample tick.
- Each channel outputs sine (quarter-wave LUT), square, sawtooth or triangle in offset-binary format.
- Channels are configured at runtime through a valid/ready port.
- Sits between the board clock and the LED/DAC outputs; replaces fixed single-channel generators.

---
 rtl/dds_wavegen_mc_if.sv | 25 ++
 rtl/dds_wavegen_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_dds_wavegen_mc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dds_wavegen_mc_if.sv
// Configuration port of the multi-channel DDS generator: valid/ready
// request carrying channel select, phase increment, phase offset,
// waveform select and channel enable.
interface dds_wavegen_mc_if #(
    parameter int CH_W    = 1,
    parameter int PHASE_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic [PHASE_W-1:0] cfg_freq;
    logic [PHASE_W-1:0] cfg_phase;
    logic [1:0]         cfg_wave;
    logic               cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_freq, cfg_phase, cfg_wave, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_freq, cfg_phase, cfg_wave, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/dds_wavegen_mc.sv
// Multi-channel DDS waveform generator. A shared programmable divider
// produces sample ticks; on each tick every channel samples its phase
// (accumulator + offset), advances its accumulator, and one cycle later
// the sine/square/saw/triangle sample is registered in offset binary.
// Optional macro WRAP_FLAG_EN adds a per-channel accumulator-carry flag
// output (wrap_flag) that pulses together with out_valid.
module dds_wavegen_mc #(
    parameter int NCH     = 2,
    parameter int CH_W    = 1,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIV_W-1:0]        div_limit,
    dds_wavegen_mc_if.slave         cfg,
    output logic                    sample_tick,
    output logic [NCH*DATA_W-1:0]   wave_out,
`ifdef WRAP_FLAG_EN
    output logic [NCH-1:0]          wrap_flag,
`endif
    output logic                    out_valid
);

    localparam int QW    = DATA_W - 1;
    localparam int LUT_N = 2 ** LUT_AW;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Round a non-negative Q30 fixed-point value to the nearest integer.
    function automatic longint round_q30(input longint v);
        return (v + (longint'(1) <<< 29)) >>> 30;
    endfunction

    // Quarter-wave sine table, evaluated at sample centres (k+0.5) with a
    // Q30 Taylor series so the ROM is fixed at elaboration.
    function automatic logic [LUT_N*QW-1:0] build_lut();
        logic [LUT_N*QW-1:0] rom;
        longint x, x2, term, sum;
        longint amp;
        rom = '0;
        amp = (longint'(1) <<< (DATA_W-1)) - 1;
        for (int k = 0; k < LUT_N; k++) begin
            x    = (HALF_PI_Q30 * longint'(2*k + 1)) / longint'(2*LUT_N);
            x2   = (x * x) >>> 30;
            term = x;
            sum  = x;
            for (int n = 1; n <= 8; n++) begin
                term = -(((term * x2) >>> 30) / longint'((2*n) * (2*n + 1)));
                sum  = sum + term;
            end
            rom[k*QW +: QW] = QW'(round_q30(amp * sum));
        end
        return rom;
    endfunction

    localparam logic [LUT_N*QW-1:0] SINE_ROM = build_lut();

    // Map a sampled phase to an output sample for the selected waveform.
    function automatic logic [DATA_W-1:0] wave_calc(
        input logic [PHASE_W-1:0] p,
        input logic [1:0]         w,
        input logic               en
    );
        logic [1:0]        qd;
        logic [LUT_AW-1:0] a;
        logic [LUT_AW-1:0] addr;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] t;
        logic [DATA_W-1:0] y;
        qd   = p[PHASE_W-1 -: 2];
        a    = p[PHASE_W-3 -: LUT_AW];
        addr = qd[0] ? ~a : a;
        q    = {1'b0, SINE_ROM[int'(addr)*QW +: QW]};
        t    = p[PHASE_W-2 -: DATA_W];
        case (w)
            2'd0:    y = qd[1] ? (MID - DATA_W'(1) - q) : (MID + q);
            2'd1:    y = {DATA_W{~p[PHASE_W-1]}};
            2'd2:    y = p[PHASE_W-1 -: DATA_W];
            default: y = p[PHASE_W-1] ? ~t : t;
        endcase
        if (!en) y = MID;
        return y;
    endfunction

    logic [DIV_W-1:0]   r_count;
    logic               r_tick;
    logic               r_ready;
    logic               w_xfer;

    logic [PHASE_W-1:0] r_acc   [NCH];
    logic [PHASE_W-1:0] r_freq  [NCH];
    logic [PHASE_W-1:0] r_phase [NCH];
    logic [1:0]         r_wave  [NCH];
    logic [NCH-1:0]     r_en;
    logic [PHASE_W-1:0] w_sum   [NCH];

    logic               r_vld_p1;
    logic [PHASE_W-1:0] r_p_p1    [NCH];
    logic [1:0]         r_wave_p1 [NCH];
    logic [NCH-1:0]     r_en_p1;

    logic               r_vld_p2;
    logic [DATA_W-1:0]  r_lane_p2 [NCH];

    assign w_xfer        = cfg.cfg_valid && r_ready;
    assign cfg.cfg_ready = r_ready;
    assign sample_tick   = r_tick;
    assign out_valid     = r_vld_p2;

    // Next accumulator value per channel, wrapping modulo 2^PHASE_W.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_sum[c] = r_acc[c] + r_freq[c];
        end
    end

    // Sample-tick divider; config port is blocked on tick cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_ready <= 1'b0;
        end else if (r_count >= div_limit) begin
            r_count <= '0;
            r_tick  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
            r_ready <= 1'b1;
        end
    end

    // Channel config and accumulators; a config write restarts the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]   <= '0;
                r_freq[c]  <= '0;
                r_phase[c] <= '0;
                r_wave[c]  <= 2'd0;
            end
            r_en <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (r_tick) begin
                    if (r_en[c]) r_acc[c] <= w_sum[c];
                end else if (w_xfer && int'(cfg.cfg_ch) == c) begin
                    r_acc[c]   <= '0;
                    r_freq[c]  <= cfg.cfg_freq;
                    r_phase[c] <= cfg.cfg_phase;
                    r_wave[c]  <= cfg.cfg_wave;
                    r_en[c]    <= cfg.cfg_en;
                end
            end
        end
    end

    // ---- stage 1: sample phase and channel mode on the tick ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_en_p1  <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_p_p1[c]    <= '0;
                r_wave_p1[c] <= 2'd0;
            end
        end else begin
            r_vld_p1 <= r_tick;
            if (r_tick) begin
                r_en_p1 <= r_en;
                for (int c = 0; c < NCH; c++) begin
                    r_p_p1[c]    <= r_acc[c] + r_phase[c];
                    r_wave_p1[c] <= r_wave[c];
                end
            end
        end
    end

    // ---- stage 2: waveform lookup and output register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2 <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_lane_p2[c] <= MID;
            end
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                for (int c = 0; c < NCH; c++) begin
                    r_lane_p2[c] <= wave_calc(r_p_p1[c], r_wave_p1[c], r_en_p1[c]);
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign wave_out[g*DATA_W +: DATA_W] = r_lane_p2[g];
    end

`ifdef WRAP_FLAG_EN
    logic [NCH-1:0] w_carry;
    logic [NCH-1:0] r_carry_p1;
    logic [NCH-1:0] r_wrap_p2;

    // Carry out of the accumulator: the wrapped sum is below the old value.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_carry[c] = r_en[c] && (w_sum[c] < r_acc[c]);
        end
    end

    // Carry travels with the sample through both pipeline stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry_p1 <= '0;
            r_wrap_p2  <= '0;
        end else begin
            if (r_tick) r_carry_p1 <= w_carry;
            r_wrap_p2 <= r_vld_p1 ? r_carry_p1 : '0;
        end
    end

    assign wrap_flag = r_wrap_p2;
`endif

endmodule

// File: tb/tb_dds_wavegen_mc.sv
// Scoreboard bench for dds_wavegen_mc (NCH=2) plus an NCH=1 instance
// used to confirm that out-of-range channel writes are dropped.
module tb_dds_wavegen_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] div_limit;

    logic        sample_tick, out_valid;
    logic [15:0] wave_out;
    logic        tick1, vld1;
    logic [7:0]  wave1;
`ifdef WRAP_FLAG_EN
    logic [1:0]  wrap_flag;
    logic [0:0]  wrap1;
`endif

    dds_wavegen_mc_if #(.CH_W(1), .PHASE_W(16)) cfg_if  ();
    dds_wavegen_mc_if #(.CH_W(1), .PHASE_W(16)) cfg_if1 ();

    dds_wavegen_mc #(.NCH(2), .CH_W(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .div_limit   (div_limit),
        .cfg         (cfg_if),
        .sample_tick (sample_tick),
        .wave_out    (wave_out),
`ifdef WRAP_FLAG_EN
        .wrap_flag   (wrap_flag),
`endif
        .out_valid   (out_valid)
    );

    dds_wavegen_mc #(.NCH(1), .CH_W(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .div_limit   (div_limit),
        .cfg         (cfg_if1),
        .sample_tick (tick1),
        .wave_out    (wave1),
`ifdef WRAP_FLAG_EN
        .wrap_flag   (wrap1),
`endif
        .out_valid   (vld1)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_tick = -1;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every out_valid; also times ticks.
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset) begin
            last_tick = -1;
        end else begin
            if (out_valid) begin
                check("latency", cyc - last_tick, 2);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got wave_out %h expected no out_valid", wave_out);
                end else begin
                    e = exp_q.pop_front();
                    check("wave_out", {16'h0, wave_out}, {16'h0, e});
                end
                check("nch1_valid", {31'h0, vld1}, 1);
                check("nch1_lane", {24'h0, wave1}, 32'h80);
            end
            if (sample_tick) begin
                if (last_tick >= 0) check("tick_period", cyc - last_tick, 4);
                last_tick = cyc;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < n*8 + 8) begin
            @(negedge clk);
            budget++;
            if (sample_tick) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: saw %0d ticks expected %0d", seen, n);
        end
    endtask

    // Issued from the negedge of a tick cycle; drops the same request onto
    // channel 1 of the single-channel instance.
    task automatic do_cfg(input logic ch, input logic [15:0] freq, input logic [15:0] phase,
                          input logic [1:0] wave, input logic en);
        int w = 0;
        check("ready_on_tick", {31'h0, cfg_if.cfg_ready}, 0);
        cfg_if.cfg_ch     = ch;
        cfg_if.cfg_freq   = freq;
        cfg_if.cfg_phase  = phase;
        cfg_if.cfg_wave   = wave;
        cfg_if.cfg_en     = en;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if1.cfg_ch    = 1'b1;
        cfg_if1.cfg_freq  = 16'h1000;
        cfg_if1.cfg_phase = 16'h0000;
        cfg_if1.cfg_wave  = 2'd2;
        cfg_if1.cfg_en    = 1'b1;
        cfg_if1.cfg_valid = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (!cfg_if.cfg_ready && w < 10);
        check("xfer_delay", w, 1);
        check("nch1_ready", {31'h0, cfg_if1.cfg_ready}, 1);
        @(posedge clk);
        #1;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if1.cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sq_a [4];
        logic [7:0] sq_b [4];
        logic [7:0] sn   [4];
        logic [7:0] tri8 [8];
        sq_a = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        sq_b = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        sn   = '{8'h80, 8'hFF, 8'h7F, 8'h00};
        tri8 = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F};

        reset     = 1'b1;
        div_limit = 26'd3;
        cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_ch  = '0; cfg_if.cfg_freq  = '0;
        cfg_if.cfg_phase  = '0;   cfg_if.cfg_wave = '0; cfg_if.cfg_en   = 1'b0;
        cfg_if1.cfg_valid = 1'b0; cfg_if1.cfg_ch = '0; cfg_if1.cfg_freq = '0;
        cfg_if1.cfg_phase = '0;   cfg_if1.cfg_wave = '0; cfg_if1.cfg_en = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_wave_out", {16'h0, wave_out}, 32'h8080);
        check("rst_tick", {31'h0, sample_tick}, 0);
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_ready", {31'h0, cfg_if.cfg_ready}, 0);

        // idle: both lanes at mid-scale
        repeat (4) exp_q.push_back(16'h8080);
        reset = 1'b0;
        wait_ticks(4);

        // ch0 sawtooth, 16 steps per cycle
        do_cfg(1'b0, 16'h1000, 16'h0000, 2'd2, 1'b1);
        for (int i = 0; i <= 16; i++) exp_q.push_back({8'h80, 8'(i*16)});
        wait_ticks(17);

        // ch0 disabled: mid-scale regardless of wave
        do_cfg(1'b0, 16'h1000, 16'h0000, 2'd2, 1'b0);
        repeat (2) exp_q.push_back(16'h8080);
        wait_ticks(2);

        // ch1 square
        do_cfg(1'b1, 16'h4000, 16'h0000, 2'd1, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back({sq_a[i%4], 8'h80});
        wait_ticks(8);

        // ch1 square restarted with half-cycle phase offset
        do_cfg(1'b1, 16'h4000, 16'h8000, 2'd1, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back({sq_b[i%4], 8'h80});
        wait_ticks(8);

        // ch0 sine at quarter-cycle steps
        do_cfg(1'b0, 16'h4000, 16'h0000, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back({sq_b[i%4], sn[i%4]});
        wait_ticks(8);

        // ch0 triangle at eighth-cycle steps
        do_cfg(1'b0, 16'h2000, 16'h0000, 2'd3, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back({sq_b[i%4], tri8[i]});
        wait_ticks(8);

        // reset between the last tick and its output: that sample is lost
        reset = 1'b1;
        void'(exp_q.pop_back());
        repeat (3) begin
            @(negedge clk);
            check("abort_valid", {31'h0, out_valid}, 0);
            check("abort_ready", {31'h0, cfg_if.cfg_ready}, 0);
            check("abort_wave_out", {16'h0, wave_out}, 32'h8080);
        end

        // after reset all channels are cleared back to mid-scale
        repeat (3) exp_q.push_back(16'h8080);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, cfg_if.cfg_ready}, 1);
        wait_ticks(3);
        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
